fifo_rd_sched: RTL and testbench

Read scheduler for the shared multi-flux FIFO. It collects per-flux read requests from downstream consumers as pulses and holds them in per-flux pending counters. Each cycle it drives the FIFO's per-flux read strobes with at most one bit set, granting by round-robin (optionally burst-weighted) among fluxes that are both pending and non-empty. It then registers the returned word and its tag towards the consumers.

---
 rtl/fifo_rd_sched_if.sv | 40 ++++
 rtl/fifo_rd_sched.sv | 185 ++++++++++++++++++
 tb/tb_fifo_rd_sched.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_sched_if.sv
// fifo_rd_sched_if
// Bundles the signals between the read scheduler, the shared multi-flux FIFO
// and the flux consumers.
//   slave  : scheduler side (takes en/req/empty/fifo_dout, drives the rest)
//   master : environment side (FIFO + consumers, or a testbench)
// Signals:
//   en        scheduling enable
//   req       per-flux read request pulses from consumers
//   empty     per-flux empty flags from the FIFO
//   fifo_dout FIFO read word {tag, data}, valid while read is asserted
//   read      per-flux FIFO read strobes, zero or one-hot
//   out_valid one-hot delivery marker towards consumers
//   out_data  delivered payload
//   out_tag   delivered tag
//   overflow  sticky per-flux request-drop flags
interface fifo_rd_sched_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FLUX       = 2,
  parameter int TAG_WIDTH  = $clog2(FLUX)
);
  logic                            en;
  logic [FLUX-1:0]                 req;
  logic [FLUX-1:0]                 empty;
  logic [TAG_WIDTH+DATA_WIDTH-1:0] fifo_dout;
  logic [FLUX-1:0]                 read;
  logic [FLUX-1:0]                 out_valid;
  logic [DATA_WIDTH-1:0]           out_data;
  logic [TAG_WIDTH-1:0]            out_tag;
  logic [FLUX-1:0]                 overflow;

  modport slave (
    input  en, req, empty, fifo_dout,
    output read, out_valid, out_data, out_tag, overflow
  );

  modport master (
    output en, req, empty, fifo_dout,
    input  read, out_valid, out_data, out_tag, overflow
  );
endinterface

// File: rtl/fifo_rd_sched.sv
// fifo_rd_sched
// Read scheduler for the shared multi-flux FIFO. Consumer request pulses are
// accumulated in per-flux pending counters; each cycle at most one FIFO read
// strobe is raised, chosen round-robin among fluxes that are pending and
// non-empty. The returned word and tag are registered towards the consumers.
// Optional feature macro: FIFO_RD_SCHED_BURST_EN
//   defined   : a granted flux may keep the grant for up to BURST cycles
//   undefined : plain single-grant round-robin, BURST unused
// Ports:
//   clk  clock, all state on posedge
//   rst  asynchronous active-low reset
//   bus  fifo_rd_sched_if.slave (en, req, empty, fifo_dout in;
//        read, out_valid, out_data, out_tag, overflow out)
module fifo_rd_sched #(
  parameter int DATA_WIDTH = 8,
  parameter int FLUX       = 2,
  parameter int MAX_PEND   = 3,
  parameter int BURST      = 2,
  parameter int TAG_WIDTH  = $clog2(FLUX),
  parameter int PEND_W     = $clog2(MAX_PEND + 1)
) (
  input logic            clk,
  input logic            rst,
  fifo_rd_sched_if.slave bus
);

  // Elaboration-time sanity check of the configuration.
  if (FLUX < 2 || MAX_PEND < 1 || BURST < 1) begin : g_bad_cfg
    $error("fifo_rd_sched: unsupported parameter set");
  end

  logic [PEND_W-1:0]     pend [FLUX];
  logic [TAG_WIDTH-1:0]  ptr;
  logic [FLUX-1:0]       elig;
  logic                  arb_found;
  logic [TAG_WIDTH-1:0]  arb_g;
  logic                  grant_found;
  logic [TAG_WIDTH-1:0]  grant_g;
  logic                  ptr_load;
  logic [FLUX-1:0]       read_c;
  logic [FLUX-1:0]       out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [TAG_WIDTH-1:0]  out_tag_q;
  logic [FLUX-1:0]       overflow_q;

  always_comb begin
    for (int i = 0; i < FLUX; i++) begin
      elig[i] = bus.en && (pend[i] != '0) && !bus.empty[i];
    end
  end

  // Rotating search: first eligible flux starting at ptr, wrapping mod FLUX.
  always_comb begin
    arb_found = 1'b0;
    arb_g     = '0;
    for (int k = 0; k < FLUX; k++) begin
      if (!arb_found && elig[(int'(ptr) + k) % FLUX]) begin
        arb_found = 1'b1;
        arb_g     = TAG_WIDTH'((int'(ptr) + k) % FLUX);
      end
    end
  end

`ifdef FIFO_RD_SCHED_BURST_EN
  localparam int BCNT_W = $clog2(BURST + 1);

  typedef enum logic {ST_ARB, ST_BURST} state_t;

  state_t               state, state_nxt;
  logic [TAG_WIDTH-1:0] cur, cur_nxt;
  logic [BCNT_W-1:0]    bcnt, bcnt_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_ARB;
      cur   <= '0;
      bcnt  <= '0;
    end else begin
      state <= state_nxt;
      cur   <= cur_nxt;
      bcnt  <= bcnt_nxt;
    end
  end

  // A burst that cannot continue falls back to the ARB search in the same
  // cycle so the handover costs no bubble.
  always_comb begin
    state_nxt   = state;
    cur_nxt     = cur;
    bcnt_nxt    = bcnt;
    grant_found = 1'b0;
    grant_g     = '0;
    ptr_load    = 1'b0;
    if (!bus.en) begin
      state_nxt = ST_ARB;
      bcnt_nxt  = '0;
    end else if (state == ST_BURST && elig[cur] && int'(bcnt) < BURST) begin
      grant_found = 1'b1;
      grant_g     = cur;
      bcnt_nxt    = bcnt + BCNT_W'(1);
      if (int'(bcnt) + 1 >= BURST) begin
        state_nxt = ST_ARB;
      end
    end else begin
      state_nxt = ST_ARB;
      bcnt_nxt  = '0;
      if (arb_found) begin
        grant_found = 1'b1;
        grant_g     = arb_g;
        ptr_load    = 1'b1;
        if (BURST > 1) begin
          state_nxt = ST_BURST;
          cur_nxt   = arb_g;
          bcnt_nxt  = BCNT_W'(1);
        end
      end
    end
  end
`else
  always_comb begin
    grant_found = arb_found;
    grant_g     = arb_g;
    ptr_load    = arb_found;
  end
`endif

  always_comb begin
    read_c = '0;
    if (grant_found) begin
      read_c[grant_g] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (ptr_load) begin
      ptr <= (int'(arb_g) + 1 == FLUX) ? '0 : arb_g + TAG_WIDTH'(1);
    end
  end

  // A request arriving at MAX_PEND without a same-cycle read is dropped and
  // flagged; request plus read at MAX_PEND is a net no-op.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FLUX; i++) begin
        pend[i] <= '0;
      end
      overflow_q <= '0;
    end else begin
      for (int i = 0; i < FLUX; i++) begin
        if (bus.req[i] && !read_c[i]) begin
          if (int'(pend[i]) == MAX_PEND) begin
            overflow_q[i] <= 1'b1;
          end else begin
            pend[i] <= pend[i] + PEND_W'(1);
          end
        end else if (!bus.req[i] && read_c[i]) begin
          pend[i] <= pend[i] - PEND_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= '0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
    end else begin
      out_valid_q <= read_c;
      if (grant_found) begin
        out_data_q <= bus.fifo_dout[DATA_WIDTH-1:0];
        out_tag_q  <= bus.fifo_dout[TAG_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
      end
    end
  end

  assign bus.read      = read_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_fifo_rd_sched.sv
// tb_fifo_rd_sched
// Self-checking bench for fifo_rd_sched (FLUX=2, DATA_WIDTH=8, MAX_PEND=3,
// BURST=2). Directed vector table plus randomized traffic, all compared
// against a behavioural model of the scheduling rules. Honours
// FIFO_RD_SCHED_BURST_EN the same way as the design.
module tb_fifo_rd_sched;
  localparam int DW    = 8;
  localparam int FLUX  = 2;
  localparam int TW    = $clog2(FLUX);
  localparam int MAXP  = 3;
  localparam int BURSTP = 2;

  logic clk;
  logic rst;

  fifo_rd_sched_if #(.DATA_WIDTH(DW), .FLUX(FLUX)) bus ();

  fifo_rd_sched #(
    .DATA_WIDTH(DW), .FLUX(FLUX), .MAX_PEND(MAXP), .BURST(BURSTP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // FIFO stand-in: each flux head word, returned with its own tag when read.
  logic [DW-1:0] words [FLUX];
  bit            fix_words = 0;

  always_comb begin
    bus.fifo_dout = {TW'(0), 8'hEE};
    for (int i = 0; i < FLUX; i++) begin
      if (bus.read[i]) bus.fifo_dout = {TW'(i), words[i]};
    end
  end

  // Behavioural model state.
  int            m_pend [FLUX];
  int            m_ptr;
  int            run_flux;
  int            run_len;
  logic [FLUX-1:0] m_ovf;
  logic [FLUX-1:0] m_out_valid;
  logic [DW-1:0]   m_out_data;
  logic [TW-1:0]   m_out_tag;
  logic [FLUX-1:0] obs_read;

  typedef struct {
    logic            en;
    logic [FLUX-1:0] req;
    logic [FLUX-1:0] empty;
    logic [FLUX-1:0] exp_read;
  } vec_t;

  vec_t vecs[$];

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < FLUX; i++) m_pend[i] = 0;
    m_ptr = 0;
    run_flux = 0;
    run_len = 0;
    m_ovf = '0;
    m_out_valid = '0;
    m_out_data = '0;
    m_out_tag = '0;
  endfunction

  // Which flux should be read this cycle; cont marks a burst continuation.
  function automatic void model_grant(input logic e, input logic [FLUX-1:0] emp,
                                      output int g, output bit cont);
    g = -1;
    cont = 0;
    if (!e) return;
`ifdef FIFO_RD_SCHED_BURST_EN
    if (run_len > 0 && run_len < BURSTP && m_pend[run_flux] > 0 && !emp[run_flux]) begin
      g = run_flux;
      cont = 1;
      return;
    end
`endif
    for (int k = 0; k < FLUX; k++) begin
      int f;
      f = (m_ptr + k) % FLUX;
      if (g < 0 && m_pend[f] > 0 && !emp[f]) g = f;
    end
  endfunction

  function automatic void model_update(input logic e, input logic [FLUX-1:0] r,
                                       input int g, input bit cont);
    if (g >= 0) begin
      m_out_valid = '0;
      m_out_valid[g] = 1'b1;
      m_out_data = words[g];
      m_out_tag = TW'(g);
    end else begin
      m_out_valid = '0;
    end
    for (int i = 0; i < FLUX; i++) begin
      if (r[i] && g != i) begin
        if (m_pend[i] == MAXP) m_ovf[i] = 1'b1;
        else m_pend[i]++;
      end else if (!r[i] && g == i) begin
        m_pend[i]--;
      end
    end
    if (g >= 0 && !cont) m_ptr = (g + 1) % FLUX;
`ifdef FIFO_RD_SCHED_BURST_EN
    if (!e || g < 0) run_len = 0;
    else if (cont) begin
      run_len++;
      if (run_len >= BURSTP) run_len = 0;
    end else begin
      run_flux = g;
      run_len = (BURSTP > 1) ? 1 : 0;
    end
`endif
  endfunction

  // One clock cycle: drive inputs after negedge, check read before the
  // posedge, then check the registered outputs just after it.
  task automatic apply_stimulus(input logic e, input logic [FLUX-1:0] r,
                                input logic [FLUX-1:0] emp);
    int g;
    bit cont;
    logic [FLUX-1:0] exp_read;
    @(negedge clk);
    bus.en = e;
    bus.req = r;
    bus.empty = emp;
    if (!fix_words) begin
      for (int i = 0; i < FLUX; i++) words[i] = DW'($urandom);
    end
    #1;
    model_grant(e, emp, g, cont);
    exp_read = '0;
    if (g >= 0) exp_read[g] = 1'b1;
    obs_read = bus.read;
    check_output("read", 32'(bus.read), 32'(exp_read));
    @(posedge clk);
    #1;
    model_update(e, r, g, cont);
    check_output("out_valid", 32'(bus.out_valid), 32'(m_out_valid));
    check_output("out_data", 32'(bus.out_data), 32'(m_out_data));
    check_output("out_tag", 32'(bus.out_tag), 32'(m_out_tag));
    check_output("overflow", 32'(bus.overflow), 32'(m_ovf));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    model_reset();
    for (int i = 0; i < FLUX; i++) words[i] = '0;
    rst = 1'b0;
    bus.en = 1'b1;
    bus.req = 2'b11;
    bus.empty = 2'b00;

    // Reset holds everything idle even with requests present.
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_read", 32'(bus.read), 32'h0);
    check_output("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check_output("rst_out_data", 32'(bus.out_data), 32'h0);
    check_output("rst_overflow", 32'(bus.overflow), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    bus.req = 2'b00;
    apply_stimulus(1'b1, 2'b00, 2'b00);
    apply_stimulus(1'b1, 2'b00, 2'b00);

    // Single request: read at t+1, delivery at t+2.
    apply_stimulus(1'b1, 2'b10, 2'b00);
    check_output("lat_read_t0", 32'(obs_read), 32'h0);
    fix_words = 1;
    words[0] = 8'h3C;
    words[1] = 8'hA5;
    apply_stimulus(1'b1, 2'b00, 2'b00);
    check_output("lat_read_t1", 32'(obs_read), 32'h2);
    check_output("lat_out_valid", 32'(bus.out_valid), 32'h2);
    check_output("lat_out_data", 32'(bus.out_data), 32'hA5);
    check_output("lat_out_tag", 32'(bus.out_tag), 32'h1);
    fix_words = 0;

    // Round-robin: preload {3,3} with en=0.
    repeat (3) vecs.push_back('{1'b0, 2'b11, 2'b00, 2'b00});
`ifdef FIFO_RD_SCHED_BURST_EN
    vecs.push_back('{1'b1, 2'b00, 2'b00, 2'b01});
    vecs.push_back('{1'b1, 2'b00, 2'b00, 2'b01});
    vecs.push_back('{1'b1, 2'b00, 2'b00, 2'b10});
    vecs.push_back('{1'b1, 2'b00, 2'b00, 2'b10});
    vecs.push_back('{1'b1, 2'b00, 2'b00, 2'b01});
    vecs.push_back('{1'b1, 2'b00, 2'b00, 2'b10});
`else
    repeat (3) begin
      vecs.push_back('{1'b1, 2'b00, 2'b00, 2'b01});
      vecs.push_back('{1'b1, 2'b00, 2'b00, 2'b10});
    end
`endif
    vecs.push_back('{1'b1, 2'b00, 2'b00, 2'b00});
    // Empty masking: pend {2,1}, flux 0 empty at first.
    repeat (2) vecs.push_back('{1'b0, 2'b01, 2'b00, 2'b00});
    vecs.push_back('{1'b0, 2'b10, 2'b00, 2'b00});
    vecs.push_back('{1'b1, 2'b00, 2'b01, 2'b10});
    repeat (2) vecs.push_back('{1'b1, 2'b00, 2'b01, 2'b00});
    repeat (2) vecs.push_back('{1'b1, 2'b00, 2'b00, 2'b01});
    vecs.push_back('{1'b1, 2'b00, 2'b00, 2'b00});
    // Overflow: four requests with en=0, then exactly three grants.
    repeat (4) vecs.push_back('{1'b0, 2'b01, 2'b00, 2'b00});
    repeat (3) vecs.push_back('{1'b1, 2'b00, 2'b00, 2'b01});
    vecs.push_back('{1'b1, 2'b00, 2'b00, 2'b00});
    // Request and read together at MAX_PEND: no drop, four grants total.
    repeat (3) vecs.push_back('{1'b0, 2'b10, 2'b00, 2'b00});
    vecs.push_back('{1'b1, 2'b10, 2'b00, 2'b10});
    repeat (3) vecs.push_back('{1'b1, 2'b00, 2'b00, 2'b10});
    vecs.push_back('{1'b1, 2'b00, 2'b00, 2'b00});

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].en, vecs[i].req, vecs[i].empty);
      check_output($sformatf("vec%0d_read", i), 32'(obs_read), 32'(vecs[i].exp_read));
    end
    check_output("ovf_sticky", 32'(bus.overflow), 32'h1);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      apply_stimulus(($urandom % 5) != 0, FLUX'($urandom), FLUX'($urandom));
    end

    // Asynchronous reset mid-cycle discards everything immediately.
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_output("arst_read", 32'(bus.read), 32'h0);
    check_output("arst_out_valid", 32'(bus.out_valid), 32'h0);
    check_output("arst_out_data", 32'(bus.out_data), 32'h0);
    check_output("arst_overflow", 32'(bus.overflow), 32'h0);
    model_reset();
    @(negedge clk);
    bus.req = 2'b00;
    rst = 1'b1;
    apply_stimulus(1'b1, 2'b00, 2'b00);
    for (int n = 0; n < 60; n++) begin
      apply_stimulus(1'b1, FLUX'($urandom), FLUX'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
